// File: rtl/pixel_fetch.sv
// Address-FIFO consumer: fetches valid pixel addresses from SRAM, substitutes a fill
// colour for invalid ones (BORDER_COLOR when PIXEL_FETCH_BORDER_EN is defined), in-order show-ahead buffer.
//
// state | meaning
// IDLE  | waiting for an address word and buffer credit; pops the FIFO
// FETCH | popped word on iADDRESS; valid -> REQ, invalid -> inject fill
// REQ   | SRAM request held until acknowledged
module pixel_fetch #(
    parameter int          MEM_LATENCY  = 2,
    parameter int          OUT_DEPTH    = 8,
    parameter logic [15:0] BORDER_COLOR = 16'h001F
) (
    input  logic        CLK,
    input  logic        RESET_N,
    output logic        oREAD,
    input  logic        iREADY_N,
    input  logic [19:0] iADDRESS,
    output logic        oMEM_REQ,
    output logic [18:0] oMEM_ADDR,
    input  logic        iMEM_ACK,
    input  logic [15:0] iMEM_DATA,
    input  logic        iPIX_READ,
    output logic [15:0] oPIX_DATA,
    output logic        oPIX_EMPTY,
    output logic        oUNDERRUN
);

    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = $clog2(OUT_DEPTH + MEM_LATENCY + 2) + 1;

`ifdef PIXEL_FETCH_BORDER_EN
    localparam logic [15:0] FILL = BORDER_COLOR;
`else
    // Fill is black in this build; the colour parameter is masked off.
    localparam logic [15:0] FILL = BORDER_COLOR & 16'h0000;
`endif

    typedef enum logic [1:0] {IDLE, FETCH, REQ} state_t;

    state_t                 state, state_next;
    logic                   run;
    logic                   inject, inject_mem;
    logic [MEM_LATENCY-1:0] pipe_live, pipe_mem;
    logic [15:0]            buf_mem [OUT_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [PW:0]            count;
    logic [15:0]            held;
    logic [CW-1:0]          pending;
    logic                   credit, wr_en, rd_en;
    logic [15:0]            wr_data;

    // Everything already committed to the buffer counts against its capacity.
    always_comb begin
        pending = CW'(count);
        for (int i = 0; i < MEM_LATENCY; i++) pending = pending + CW'(pipe_live[i]);
        if (state != IDLE) pending = pending + CW'(1);
    end
    assign credit = pending < CW'(OUT_DEPTH);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            run   <= 1'b0;
        end else begin
            state <= state_next;
            run   <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        oREAD      = 1'b0;
        inject     = 1'b0;
        inject_mem = 1'b0;
        case (state)
            IDLE: begin
                if (run && !iREADY_N && credit) begin
                    oREAD      = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (iADDRESS[19]) begin
                    state_next = REQ;
                end else begin
                    inject     = 1'b1;
                    state_next = IDLE;
                end
            end
            REQ: begin
                if (iMEM_ACK) begin
                    inject     = 1'b1;
                    inject_mem = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign oMEM_REQ = (state == REQ);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            oMEM_ADDR <= '0;
        end else if (state == FETCH && iADDRESS[19]) begin
            oMEM_ADDR <= iADDRESS[18:0];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pipe_live <= '0;
            pipe_mem  <= '0;
        end else begin
            pipe_live[0] <= inject;
            pipe_mem[0]  <= inject_mem;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_live[i] <= pipe_live[i-1];
                pipe_mem[i]  <= pipe_mem[i-1];
            end
        end
    end

    assign wr_en   = pipe_live[MEM_LATENCY-1];
    assign wr_data = pipe_mem[MEM_LATENCY-1] ? iMEM_DATA : FILL;
    assign rd_en   = iPIX_READ && (count != '0);

    always_ff @(posedge CLK) begin
        if (wr_en) buf_mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            held      <= '0;
            oUNDERRUN <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            // Track the visible head so the output freezes once the buffer drains.
            if (count != '0) held <= buf_mem[rd_ptr];
            if (iPIX_READ && count == '0) oUNDERRUN <= 1'b1;
        end
    end

    assign oPIX_EMPTY = (count == '0);
    assign oPIX_DATA  = oPIX_EMPTY ? held : buf_mem[rd_ptr];

endmodule

// File: tb/tb_pixel_fetch.sv
// Directed bench for pixel_fetch with an address-FIFO model and a fixed-latency SRAM model.
module tb_pixel_fetch;

    localparam int MEM_LAT = 2;
`ifdef PIXEL_FETCH_BORDER_EN
    localparam logic [15:0] FILL = 16'h001F;
`else
    localparam logic [15:0] FILL = 16'h0000;
`endif

    logic        CLK;
    logic        RESET_N;
    logic        oREAD;
    logic        iREADY_N;
    logic [19:0] iADDRESS;
    logic        oMEM_REQ;
    logic [18:0] oMEM_ADDR;
    logic        iMEM_ACK;
    logic [15:0] iMEM_DATA;
    logic        iPIX_READ;
    logic [15:0] oPIX_DATA;
    logic        oPIX_EMPTY;
    logic        oUNDERRUN;

    pixel_fetch #(.MEM_LATENCY(MEM_LAT), .OUT_DEPTH(8), .BORDER_COLOR(16'h001F)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .oREAD(oREAD), .iREADY_N(iREADY_N),
        .iADDRESS(iADDRESS), .oMEM_REQ(oMEM_REQ), .oMEM_ADDR(oMEM_ADDR),
        .iMEM_ACK(iMEM_ACK), .iMEM_DATA(iMEM_DATA), .iPIX_READ(iPIX_READ),
        .oPIX_DATA(oPIX_DATA), .oPIX_EMPTY(oPIX_EMPTY), .oUNDERRUN(oUNDERRUN)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [19:0] fifo_q[$];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [18:0] a);
        return (a == 19'h00123) ? 16'hBEEF : a[15:0];
    endfunction

    // Address FIFO: pop seen during cycle t presents the word during t+1.
    initial begin
        logic rd;
        iREADY_N = 1'b1;
        iADDRESS = '0;
        forever begin
            @(negedge CLK);
            #2;
            rd = oREAD;
            if (rd) chk("read_gate", {31'd0, iREADY_N}, 32'd0);
            @(posedge CLK);
            #1;
            if (rd && fifo_q.size() != 0) iADDRESS = fifo_q.pop_front();
            iREADY_N = (fifo_q.size() == 0);
        end
    end

    // SRAM: data for an ack in cycle a is driven during cycle a+MEM_LAT.
    initial begin
        logic        acc;
        logic [18:0] a;
        logic        hv [MEM_LAT];
        logic [18:0] ha [MEM_LAT];
        for (int i = 0; i < MEM_LAT; i++) begin
            hv[i] = 1'b0;
            ha[i] = '0;
        end
        iMEM_DATA = 16'hDEAD;
        forever begin
            @(negedge CLK);
            #2;
            acc = oMEM_REQ && iMEM_ACK;
            a   = oMEM_ADDR;
            @(posedge CLK);
            #1;
            for (int i = MEM_LAT - 1; i > 0; i--) begin
                hv[i] = hv[i-1];
                ha[i] = ha[i-1];
            end
            hv[0] = acc;
            ha[0] = a;
            iMEM_DATA = hv[MEM_LAT-1] ? mem_word(ha[MEM_LAT-1]) : 16'hDEAD;
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic pop_check(input string tag, input logic [15:0] exp);
        for (int i = 0; i < 60 && oPIX_EMPTY; i++) tick();
        chk({tag, "_avail"}, {31'd0, oPIX_EMPTY}, 32'd0);
        chk(tag, {16'd0, oPIX_DATA}, {16'd0, exp});
        iPIX_READ = 1'b1;
        tick();
        iPIX_READ = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_read"}, {31'd0, oREAD}, 32'd0);
        chk({tag, "_req"}, {31'd0, oMEM_REQ}, 32'd0);
        chk({tag, "_addr"}, {13'd0, oMEM_ADDR}, 32'd0);
        chk({tag, "_data"}, {16'd0, oPIX_DATA}, 32'd0);
        chk({tag, "_empty"}, {31'd0, oPIX_EMPTY}, 32'd1);
        chk({tag, "_underrun"}, {31'd0, oUNDERRUN}, 32'd0);
    endtask

    initial begin
        int n_rd;
        RESET_N   = 1'b0;
        iMEM_ACK  = 1'b1;
        iPIX_READ = 1'b0;
        fifo_q.push_back(20'h80123);

        // Single valid fetch with exact cycle timing
        repeat (3) tick();
        check_reset_values("rst");
        RESET_N = 1'b1;
        chk("c0_read", {31'd0, oREAD}, 32'd0);
        tick();
        chk("c1_read", {31'd0, oREAD}, 32'd1);
        tick();
        chk("c2_req", {31'd0, oMEM_REQ}, 32'd0);
        tick();
        chk("c3_req", {31'd0, oMEM_REQ}, 32'd1);
        chk("c3_addr", {13'd0, oMEM_ADDR}, 32'h00123);
        tick();
        chk("c4_read", {31'd0, oREAD}, 32'd0);
        tick();
        chk("c5_empty", {31'd0, oPIX_EMPTY}, 32'd1);
        tick();
        chk("c6_empty", {31'd0, oPIX_EMPTY}, 32'd0);
        chk("c6_data", {16'd0, oPIX_DATA}, 32'hBEEF);
        iPIX_READ = 1'b1;
        tick();
        iPIX_READ = 1'b0;
        chk("c7_empty", {31'd0, oPIX_EMPTY}, 32'd1);
        chk("c7_hold", {16'd0, oPIX_DATA}, 32'hBEEF);

        // Mixed valid / invalid ordering
        fifo_q.push_back(20'h80011);
        fifo_q.push_back(20'h00022);
        fifo_q.push_back(20'h80A33);
        fifo_q.push_back(20'h7FFFF);
        fifo_q.push_back(20'hCBCDE);
        pop_check("mix0", 16'h0011);
        pop_check("mix1", FILL);
        pop_check("mix2", 16'h0A33);
        pop_check("mix3", FILL);
        pop_check("mix4", 16'hBCDE);

        // Credit: buffer fills to 8 with the display stalled
        for (int i = 0; i < 10; i++) fifo_q.push_back(20'h80100 + 20'(i));
        repeat (80) tick();
        chk("full_left", fifo_q.size(), 32'd2);
        n_rd = 0;
        for (int i = 0; i < 10; i++) begin
            n_rd += int'(oREAD);
            tick();
        end
        chk("full_noread", n_rd, 32'd0);
        pop_check("full_pop0", 16'h0100);
        repeat (30) tick();
        chk("refetch_one", fifo_q.size(), 32'd1);
        for (int i = 1; i < 10; i++) pop_check("full_drain", 16'h0100 + 16'(i));

        // Acknowledge withheld in REQ
        iMEM_ACK = 1'b0;
        fifo_q.push_back(20'h92345);
        for (int i = 0; i < 20 && !oMEM_REQ; i++) tick();
        for (int i = 0; i < 5; i++) begin
            chk("hold_req", {31'd0, oMEM_REQ}, 32'd1);
            chk("hold_addr", {13'd0, oMEM_ADDR}, 32'h12345);
            tick();
        end
        iMEM_ACK = 1'b1;
        tick();
        pop_check("hold_pix", 16'h2345);
        repeat (10) tick();
        chk("hold_single", {31'd0, oPIX_EMPTY}, 32'd1);

        // Underrun is sticky across refill
        iPIX_READ = 1'b1;
        tick();
        iPIX_READ = 1'b0;
        chk("underrun_set", {31'd0, oUNDERRUN}, 32'd1);
        fifo_q.push_back(20'h80055);
        for (int i = 0; i < 30 && oPIX_EMPTY; i++) tick();
        chk("underrun_refill", {31'd0, oUNDERRUN}, 32'd1);
        pop_check("underrun_pix", 16'h0055);
        chk("underrun_keep", {31'd0, oUNDERRUN}, 32'd1);

        // Reset with one pixel in the return pipe and a second word being fetched
        fifo_q.push_back(20'h80201);
        fifo_q.push_back(20'h80202);
        for (int i = 0; i < 20 && !oREAD; i++) tick();
        repeat (4) tick();
        RESET_N = 1'b0;
        fifo_q.delete();
        #1;
        check_reset_values("midrst");
        repeat (3) tick();
        RESET_N = 1'b1;
        repeat (12) tick();
        chk("no_stale_empty", {31'd0, oPIX_EMPTY}, 32'd1);
        chk("no_stale_req", {31'd0, oMEM_REQ}, 32'd0);
        fifo_q.push_back(20'h80077);
        pop_check("post_rst", 16'h0077);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/pixel_fetch.md
# pixel_fetch

Read-side consumer of the pixel-map address FIFO. Pops `{valid, address}` words, issues SRAM read requests for valid addresses, and substitutes a fill colour for invalid ones. Read data is returned in strict order into an internal show-ahead pixel buffer drained by the display stream. Sits between the pixel-map address FIFO, the shared SRAM arbiter and the display pixel serialiser.

## Interface
Parameters:
- `MEM_LATENCY`, 2: cycles from the `iMEM_ACK` cycle to the cycle `iMEM_DATA` is sampled (≥1).
- `OUT_DEPTH`, 8: pixel buffer entries (power of 2, ≥4).
- `BORDER_COLOR`, 16'h001F: substitute pixel for invalid addresses; used only with `PIXEL_FETCH_BORDER_EN`.

Ports:
- `CLK` in 1: clock.
- `RESET_N` in 1: reset, asynchronous, active-low.
- `oREAD` out 1: pop request to the address FIFO (normal mode, data valid the following cycle).
- `iREADY_N` in 1: address FIFO empty.
- `iADDRESS` in 20: bit 19 = address valid, bits 18:0 = pixel word address.
- `oMEM_REQ` out 1: SRAM read request, held until acknowledged.
- `oMEM_ADDR` out 19: read address, stable while `oMEM_REQ` is high.
- `iMEM_ACK` in 1: arbiter accepted the request this cycle.
- `iMEM_DATA` in 16: read data.
- `iPIX_READ` in 1: display pops the buffer head.
- `oPIX_DATA` out 16: buffer head (show-ahead).
- `oPIX_EMPTY` out 1: buffer empty.
- `oUNDERRUN` out 1: sticky underrun flag.

## Operation
- FSM states: IDLE, FETCH, REQ.
  - IDLE: if `!iREADY_N && credit`, assert `oREAD` for 1 cycle and go to FETCH.
  - FETCH: sample `iADDRESS`.
    - Bit 19 = 1: latch bits 18:0 into `oMEM_ADDR` and go to REQ.
    - Bit 19 = 0: inject a fill entry into the return pipeline and go to IDLE.
  - REQ: `oMEM_REQ` = 1. On `iMEM_ACK`, inject a memory entry into the return pipeline, drop `oMEM_REQ` and go to IDLE.
- Return pipeline: `MEM_LATENCY`-stage shift register of `{live, is_mem}`.
  - At the final stage, a live entry writes `iMEM_DATA` (if `is_mem`) or the fill value (otherwise) into the buffer.
  - Ordering is therefore preserved between fill and memory pixels.
- Credit: `credit = (occupancy + pipeline_live + fsm_inflight) < OUT_DEPTH`.
  - `fsm_inflight` = 1 in FETCH and REQ.
  - The buffer therefore never overflows and no write is ever dropped.
- Buffer: circular, occupancy counter `$clog2(OUT_DEPTH)+1` bits; pointers wrap at `OUT_DEPTH`.
  - Simultaneous write and pop leaves occupancy unchanged.
  - Pop on empty: ignored, and sets `oUNDERRUN` (cleared only by reset).
  - `oPIX_DATA` holds its last value when empty.
- Best-case throughput: 1 pixel per 3 cycles (IDLE→FETCH→REQ with immediate ack; an invalid address takes 2 cycles).

## Timing
- Reset values: `oREAD`=0, `oMEM_REQ`=0, `oMEM_ADDR`=0, `oPIX_DATA`=0, `oPIX_EMPTY`=1, `oUNDERRUN`=0. FSM=IDLE, pipeline and buffer cleared.
- `oREAD` at cycle t, `iADDRESS` sampled at t+1, `oMEM_REQ` high from t+2.
- Ack at cycle a: data sampled at a+`MEM_LATENCY`; `oPIX_EMPTY` falls and the pixel appears at a+`MEM_LATENCY`+1.
- Invalid address sampled at t+1: fill pixel visible at t+1+`MEM_LATENCY`+1.
- `iMEM_ACK` is ignored outside REQ.
- `oREAD` is never asserted while `iREADY_N`=1 or credit=0.
- Reset mid-operation:
  - Outstanding requests are abandoned and late `iMEM_DATA` is discarded.
  - The popped address is lost; the upstream FIFO is reset in the same domain.

## Configuration
- `PIXEL_FETCH_BORDER_EN` defined: fill value = `BORDER_COLOR`.
- `PIXEL_FETCH_BORDER_EN` undefined: fill value = 16'h0000 and `BORDER_COLOR` is unused.
- All timing is identical in both builds.

## Test plan
- Reset, FIFO holds valid 0x00123, `iMEM_ACK` tied 1, memory returns 0xBEEF:
  - `oREAD` at cycle 1, `oMEM_REQ`/`oMEM_ADDR`=0x00123 at cycle 3.
  - `oPIX_DATA`=0xBEEF with `oPIX_EMPTY`=0 at cycle 6 (`MEM_LATENCY`=2).
- Alternating valid and invalid addresses, memory data = address low bits:
  - Output order matches input order exactly.
  - Invalid slots read 0x0000, or 0x001F with the macro defined.
- `iPIX_READ` held 0:
  - After 8 pixels enter the buffer, `oREAD` stays 0 although `iREADY_N`=0.
  - One pop re-enables exactly one fetch.
- `iMEM_ACK` withheld 5 cycles in REQ: `oMEM_REQ` and `oMEM_ADDR` stay stable; exactly one entry results.
- `iPIX_READ` while `oPIX_EMPTY`=1: `oUNDERRUN`=1 persists after the buffer refills and clears only on `RESET_N`.
- `RESET_N` pulsed while 2 reads are in flight: all outputs return to reset values and no stale pixel enters the buffer afterwards.
